// File: rtl/serial_word_collector_pkg.sv
// serial_collect_pkg: shared types, default sizes and counter-load helper
// for the serial word collector.
package serial_collect_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Value loaded into the bit counter on a start bit: the number of bits
    // still to come after it (an extra one when a parity bit trails the word).
    function automatic int unsigned cnt_load_value(input int unsigned width,
                                                   input bit parity);
        return parity ? width : width - 1;
    endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// serial_word_collector_if: serial input side and parallel valid/ready output
// side of the collector. The par_err signal only exists when
// SERIAL_COLLECT_PARITY_EN is defined.
interface serial_word_collector_if #(
    parameter int WIDTH = serial_collect_pkg::DEFAULT_WIDTH
);
    logic             s_valid;
    logic             s_bit;
    logic             s_start;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             ovr_clr;
`ifdef SERIAL_COLLECT_PARITY_EN
    logic             par_err;

    modport master (
        output s_valid, s_bit, s_start, out_ready, ovr_clr,
        input  busy, data_out, out_valid, overrun, par_err
    );

    modport slave (
        input  s_valid, s_bit, s_start, out_ready, ovr_clr,
        output busy, data_out, out_valid, overrun, par_err
    );
`else
    modport master (
        output s_valid, s_bit, s_start, out_ready, ovr_clr,
        input  busy, data_out, out_valid, overrun
    );

    modport slave (
        input  s_valid, s_bit, s_start, out_ready, ovr_clr,
        output busy, data_out, out_valid, overrun
    );
`endif
endinterface

// File: rtl/serial_word_collector_bit_counter.sv
// collect_bit_counter: loadable down-counter tracking how many bits of the
// current word remain; last flags the final bit (count == 1).
module collect_bit_counter #(
    parameter int CNT_W = serial_collect_pkg::DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    // Load on a start bit, otherwise step down; never wraps below zero.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: LSB-first serial-to-parallel receiver with a
// one-word valid/ready holding register and a sticky overrun flag.
// Optional trailing even-parity bit and par_err output are enabled by
// defining SERIAL_COLLECT_PARITY_EN.
module serial_word_collector
    import serial_collect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   clr_n,
    serial_word_collector_if.slave bus
);

`ifdef SERIAL_COLLECT_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(cnt_load_value(WIDTH, PARITY));
    // With a one-bit word and no parity the start bit is also the last bit.
    localparam bit START_COMPLETES = (LOAD_VAL == '0);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             cnt_last;
    logic             start_bit;
    logic             data_bit;
    logic             shift_en;
    logic             complete;
    logic             accept;
    logic             drop;
`ifdef SERIAL_COLLECT_PARITY_EN
    logic             par_calc;
    logic             par_err_q;
`endif

    if (WIDTH > 1) begin : g_shift_wide
        assign shifted = {bus.s_bit, shreg[WIDTH-1:1]};
    end else begin : g_shift_one
        assign shifted = bus.s_bit;
    end

    assign start_bit = bus.s_valid && ((state == ST_IDLE) || bus.s_start);
    assign data_bit  = bus.s_valid && (state == ST_SHIFT) && !bus.s_start;
    assign complete  = (start_bit && START_COMPLETES) || (data_bit && cnt_last);
    assign accept    = complete && (!out_valid_q || bus.out_ready);
    assign drop      = complete && out_valid_q && !bus.out_ready;

`ifdef SERIAL_COLLECT_PARITY_EN
    // The trailing parity bit is checked but never shifted into the word.
    assign shift_en = start_bit || (data_bit && !cnt_last);
    assign word     = shreg;
    assign par_calc = (^shreg) ^ bus.s_bit;
`else
    assign shift_en = start_bit || data_bit;
    assign word     = shifted;
`endif

    collect_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (start_bit),
        .load_val (LOAD_VAL),
        .dec      (data_bit && !cnt_last),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a start bit opens a word, the final bit closes it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    state_next = START_COMPLETES ? ST_IDLE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.s_valid) begin
                    if (bus.s_start) begin
                        state_next = START_COMPLETES ? ST_IDLE : ST_SHIFT;
                    end else if (cnt_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered holding stage.
    always_comb begin
        bus.busy      = (state == ST_SHIFT);
        bus.data_out  = data_q;
        bus.out_valid = out_valid_q;
        bus.overrun   = overrun_q;
`ifdef SERIAL_COLLECT_PARITY_EN
        bus.par_err   = par_err_q;
`endif
    end

    // Shift each accepted data bit in from the top so bit 0 ends up LSB.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= shifted;
        end
    end

    // Holding register: capture a finished word when the slot is free or
    // being emptied this cycle; otherwise keep the old word untouched.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            data_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_COLLECT_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else if (accept) begin
            data_q      <= word;
            out_valid_q <= 1'b1;
`ifdef SERIAL_COLLECT_PARITY_EN
            par_err_q   <= par_calc;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word sets it even if a clear arrives together.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed stimulus with a scoreboard queue of
// expected words, popped by a monitor on every output transfer.
module tb_serial_word_collector;

    localparam int WIDTH = 8;
`ifdef SERIAL_COLLECT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             perr;
    } exp_t;

    logic clk;
    logic clr_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    serial_word_collector_if #(.WIDTH(WIDTH)) bus ();

    serial_word_collector #(
        .WIDTH (WIDTH),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every handshake transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (clr_n && bus.out_valid && bus.out_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL sb_unexpected: got word %h, expected none", bus.data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.data_out !== e.data) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_data: got %h, expected %h", bus.data_out, e.data);
                end
`ifdef SERIAL_COLLECT_PARITY_EN
                tests_run++;
                if (bus.par_err !== e.perr) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_par_err: got %b, expected %b", bus.par_err, e.perr);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic start);
        bus.s_valid = 1'b1;
        bus.s_bit   = b;
        bus.s_start = start;
        tick();
        bus.s_valid = 1'b0;
        bus.s_start = 1'b0;
    endtask

    // Send one word LSB-first; gapAt inserts three idle cycles before that
    // bit index; readyOnLast raises out_ready just before the final bit.
    task automatic sendWord(input logic [WIDTH-1:0] w, input bit badPar,
                            input bit push, input int gapAt, input bit readyOnLast);
        exp_t e;
        logic [NBITS-1:0] bits;
        e.data = w;
        e.perr = badPar;
        if (push) sb.push_back(e);
`ifdef SERIAL_COLLECT_PARITY_EN
        bits = {(^w) ^ badPar, w};
`else
        bits = w;
`endif
        for (int i = 0; i < NBITS; i++) begin
            if (i == gapAt) begin
                for (int g = 0; g < 3; g++) tick();
            end
            if (readyOnLast && (i == NBITS - 1)) bus.out_ready = 1'b1;
            applyStimulus(bits[i], i == 0);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        clr_n         = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_bit     = 1'b0;
        bus.s_start   = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovr_clr   = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_data_out",  32'(bus.data_out),  32'd0);
        checkOutput("reset_busy",      32'(bus.busy),      32'd0);
        checkOutput("reset_overrun",   32'(bus.overrun),   32'd0);

        // Basic word, consumer always ready.
        bus.out_ready = 1'b1;
        sendWord(8'hA5, 1'b0, 1'b1, -1, 1'b0);
        checkOutput("basic_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("basic_data",      32'(bus.data_out),  32'hA5);
        checkOutput("basic_busy",      32'(bus.busy),      32'd0);
        tick();
        checkOutput("basic_valid_drop", 32'(bus.out_valid), 32'd0);

        // Gaps mid-word and backpressure.
        bus.out_ready = 1'b0;
        sendWord(8'h3C, 1'b0, 1'b1, 3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_data",      32'(bus.data_out),  32'h3C);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_cleared", 32'(bus.out_valid), 32'd0);

        // Overrun: second word dropped while the first is held.
        bus.out_ready = 1'b0;
        sendWord(8'h11, 1'b0, 1'b1, -1, 1'b0);
        sendWord(8'h22, 1'b0, 1'b0, -1, 1'b0);
        checkOutput("ovr_data",  32'(bus.data_out), 32'h11);
        checkOutput("ovr_flag",  32'(bus.overrun),  32'd1);
        checkOutput("ovr_valid", 32'(bus.out_valid), 32'd1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        checkOutput("ovr_cleared",    32'(bus.overrun),  32'd0);
        checkOutput("ovr_data_after", 32'(bus.data_out), 32'h11);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("ovr_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back: new word completes in the same cycle the old one leaves.
        bus.out_ready = 1'b0;
        sendWord(8'h0F, 1'b0, 1'b1, -1, 1'b0);
        sendWord(8'hF0, 1'b0, 1'b1, -1, 1'b1);
        checkOutput("b2b_valid",   32'(bus.out_valid), 32'd1);
        checkOutput("b2b_data",    32'(bus.data_out),  32'hF0);
        checkOutput("b2b_overrun", 32'(bus.overrun),   32'd0);
        tick();
        checkOutput("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Resync: partial word aborted by a new start bit.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resync_busy", 32'(bus.busy), 32'd1);
        sendWord(8'h81, 1'b0, 1'b1, -1, 1'b0);
        checkOutput("resync_data", 32'(bus.data_out), 32'h81);
        tick();
        checkOutput("resync_drained", 32'(bus.out_valid), 32'd0);

        // Reset mid-word with a held word and a pending overrun.
        bus.out_ready = 1'b0;
        sendWord(8'h55, 1'b0, 1'b0, -1, 1'b0);
        sendWord(8'hAA, 1'b0, 1'b0, -1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pre_rst_busy",    32'(bus.busy),    32'd1);
        checkOutput("pre_rst_overrun", 32'(bus.overrun), 32'd1);
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data_out",  32'(bus.data_out),  32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_overrun",   32'(bus.overrun),   32'd0);
        bus.out_ready = 1'b1;
        sendWord(8'h96, 1'b0, 1'b1, -1, 1'b0);
        checkOutput("post_rst_data", 32'(bus.data_out), 32'h96);
        tick();

`ifdef SERIAL_COLLECT_PARITY_EN
        // Parity: correct and corrupted parity on the same data.
        sendWord(8'h07, 1'b0, 1'b1, -1, 1'b0);
        checkOutput("par_ok_data", 32'(bus.data_out), 32'h07);
        checkOutput("par_ok_err",  32'(bus.par_err),  32'd0);
        tick();
        sendWord(8'h07, 1'b1, 1'b1, -1, 1'b0);
        checkOutput("par_bad_data", 32'(bus.data_out), 32'h07);
        checkOutput("par_bad_err",  32'(bus.par_err),  32'd1);
        tick();
`endif

        tick();
        tick();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
